// File: rtl/ql_fifo_pkg.sv
// Shared types and helpers for the ql FIFO controller family.
// Pointer-width derivation, depth legality check and the packed flag bundle.
package ql_fifo_pkg;

    function automatic int unsigned ql_fifo_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic bit ql_fifo_depth_ok(input int unsigned depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic aempty;
        logic afull;
        logic ovf;
        logic udf;
    } fifo_flags_t;

    localparam fifo_flags_t FlagsRst = '{
        empty:  1'b1,
        full:   1'b0,
        aempty: 1'b1,
        afull:  1'b0,
        ovf:    1'b0,
        udf:    1'b0
    };

endpackage

// File: rtl/ql_sync_fifo_pf_if.sv
// Fabric-side bundle of the FIFO: requests, data, thresholds and status flags.
// master = fabric logic driving requests, slave = the FIFO controller.
interface ql_sync_fifo_pf_if #(
    parameter int unsigned DATA_W = 36,
    parameter int unsigned AW     = 10
);
    logic              flush;
    logic              protect;
    logic              push;
    logic [DATA_W-1:0] wdata;
    logic              pop;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [AW-1:0]     upae;
    logic [AW-1:0]     upaf;
    logic [AW:0]       count;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, protect, push, wdata, pop, upae, upaf,
        input  rdata, rvalid, count, empty, full, almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  flush, protect, push, wdata, pop, upae, upaf,
        output rdata, rvalid, count, empty, full, almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/ql_fifo_sdp_mem.sv
// Simple dual-port array: synchronous write, registered read with enable.
// No reset on the storage or read register so it maps onto block RAM.
module ql_fifo_sdp_mem #(
    parameter int unsigned DATA_W = 36,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ql_sync_fifo_pf.sv
// Single-clock FIFO controller: pointers, occupancy count, registered flags, read valid.
// Occupancy lives in its own counter; fullness is never derived from pointer compares.
module ql_sync_fifo_pf
    import ql_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 36,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned AW     = ql_fifo_aw(DEPTH)
) (
    input  logic                 CLK_i,
    input  logic                 RESET_ni,
    ql_sync_fifo_pf_if.slave     bus
);
    localparam bit DepthOk = ql_fifo_depth_ok(DEPTH);
    localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

    if (!DepthOk) begin : g_depth_check
        $error("ql_sync_fifo_pf: DEPTH must be a power of two and at least 4");
    end

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [AW:0]       af_thr;
    fifo_flags_t       flags_q, flags_d;
    logic              rvalid_q, rvalid_d;
    logic              rd_seen_q, rd_seen_d;
    logic              push_acc, pop_acc;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        push_acc  = bus.push & ~bus.protect & ~flags_q.full & ~bus.flush;
        pop_acc   = bus.pop & ~flags_q.empty & ~bus.flush;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rvalid_d  = pop_acc;
        rd_seen_d = rd_seen_q | pop_acc;
        af_thr    = DepthW - {1'b0, bus.upaf};

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push_acc) - (AW+1)'(pop_acc);
        end

        // Flags track the next-state count so they line up with COUNT_o after the edge.
        flags_d.empty  = (count_d == '0);
        flags_d.full   = (count_d == DepthW);
        flags_d.aempty = (count_d <= {1'b0, bus.upae});
        flags_d.afull  = (count_d >= af_thr);
        flags_d.ovf    = ~bus.flush & (flags_q.ovf | (bus.push & ~bus.protect & flags_q.full));
        flags_d.udf    = ~bus.flush & (flags_q.udf | (bus.pop & flags_q.empty));
    end

    always_ff @(posedge CLK_i or negedge RESET_ni) begin
        if (!RESET_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            flags_q   <= FlagsRst;
            rvalid_q  <= 1'b0;
            rd_seen_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            flags_q   <= flags_d;
            rvalid_q  <= rvalid_d;
            rd_seen_q <= rd_seen_d;
        end
    end

    ql_fifo_sdp_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk_i   (CLK_i),
        .we_i    (push_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wdata),
        .re_i    (pop_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // The RAM read register has no reset; mask it until the first pop since reset.
    assign bus.rdata        = rd_seen_q ? mem_rdata : '0;
    assign bus.rvalid       = rvalid_q;
    assign bus.count        = count_q;
    assign bus.empty        = flags_q.empty;
    assign bus.full         = flags_q.full;
    assign bus.almost_empty = flags_q.aempty;
    assign bus.almost_full  = flags_q.afull;
    assign bus.overflow     = flags_q.ovf;
    assign bus.underflow    = flags_q.udf;
endmodule

// File: tb/tb_ql_sync_fifo_pf.sv
// Randomised self-checking bench for ql_sync_fifo_pf against a queue-based reference model.
module tb_ql_sync_fifo_pf;
    localparam int unsigned DW    = 36;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic clk;
    logic rst_n;

    ql_sync_fifo_pf_if #(.DATA_W(DW), .AW(AW)) bus ();

    ql_sync_fifo_pf #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK_i    (clk),
        .RESET_ni (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [DW-1:0] model_q[$];
    bit            m_ovf, m_udf, m_rvalid;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] next_word;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic compare_all(input string tag);
        int n;
        logic [6:0] exp_flags;
        logic [6:0] got_flags;
        n = model_q.size();
        exp_flags = {n == 0, n == DEPTH, n <= int'(bus.upae), n >= DEPTH - int'(bus.upaf),
                     m_ovf, m_udf, m_rvalid};
        got_flags = {bus.empty, bus.full, bus.almost_empty, bus.almost_full,
                     bus.overflow, bus.underflow, bus.rvalid};
        check_eq({tag, ".count"}, 64'(bus.count), 64'(n));
        check_eq({tag, ".flags"}, 64'(got_flags), 64'(exp_flags));
        check_eq({tag, ".rdata"}, 64'(bus.rdata), 64'(m_rdata));
    endtask

    // Called right after a falling edge: apply inputs, advance model, clock, compare.
    task automatic step(input string tag, input bit push, input bit pop, input bit flush,
                        input bit protect, input logic [DW-1:0] wd);
        int n;
        bus.push    = push;
        bus.pop     = pop;
        bus.flush   = flush;
        bus.protect = protect;
        bus.wdata   = wd;
        n = model_q.size();
        if (flush) begin
            model_q.delete();
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_rvalid = 1'b0;
        end else begin
            m_rvalid = pop && (n != 0);
            if (m_rvalid) m_rdata = model_q.pop_front();
            if (push && !protect) begin
                if (n == DEPTH) m_ovf = 1'b1;
                else model_q.push_back(wd);
            end
            if (pop && n == 0) m_udf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic push_word(input string tag);
        next_word = next_word + 1;
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, next_word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b1;
        bus.flush   = 1'b0;
        bus.protect = 1'b0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.wdata   = '0;
        bus.upae    = 4'd2;
        bus.upaf    = 4'd3;
        next_word   = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #2 compare_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all("reset_release");

        // Fill with 1..16, one dropped push, drain, one dropped pop.
        for (int i = 0; i < DEPTH; i++) push_word("fill");
        step("overflow", 1'b1, 1'b0, 1'b0, 1'b0, 36'hA_AAAA_AAAA);
        step("ovf_sticky", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step("underflow", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step("flush0", 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // Steady state at count 8 with pointer wrap.
        for (int i = 0; i < 8; i++) push_word("pre8");
        for (int i = 0; i < 20; i++) begin
            next_word = next_word + 1;
            step("pushpop8", 1'b1, 1'b1, 1'b0, 1'b0, next_word);
        end
        while (model_q.size() < DEPTH) push_word("fill2");
        next_word = next_word + 1;
        step("pushpop_full", 1'b1, 1'b1, 1'b0, 1'b0, next_word);
        for (int i = 0; i < 10; i++) step("to5", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step("flush_all", 1'b1, 1'b1, 1'b1, 1'b0, 36'h5_5555_5555);
        step("post_flush", 1'b0, 1'b0, 1'b0, 1'b0, '0);

        // Write protect: pushes ignored, pops keep working.
        for (int i = 0; i < 4; i++) step("protect0", 1'b1, 1'b0, 1'b0, 1'b1, 36'h1_2345_6789);
        for (int i = 0; i < 3; i++) push_word("unprot");
        for (int i = 0; i < 4; i++) step("prot_pop", 1'b1, 1'b1, 1'b0, 1'b1, 36'hF_0F0F_0F0F);

        // Randomised traffic with occasional flush, protect and threshold changes.
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                bus.upae = 4'($urandom_range(0, 15));
                bus.upaf = 4'($urandom_range(0, 15));
            end
            step("rand", $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10,
                 {$urandom(), 4'($urandom())});
        end

        // Asynchronous reset between edges at count 7.
        bus.upae = 4'd2;
        bus.upaf = 4'd3;
        step("pre_rst_flush", 1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 7; i++) push_word("pre_rst");
        step("pre_rst_pop", 1'b1, 1'b1, 1'b0, 1'b0, 36'h7_7777_7777);
        #2 rst_n = 1'b0;
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        @(negedge clk);
        compare_all("rst_hold");
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step("post_rst", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, 1'b0,
                 {$urandom(), 4'($urandom())});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
